// File: rtl/g2_chain_walker_if.sv
// Job, update, table and result signals of the G2 chain walker.
// The walker uses the slave modport; the job source, update engine,
// table and result sink together form the master side.
interface g2_chain_walker_if #(
  parameter int INDEX_BIT_LEN    = 11,
  parameter int PACKET_BIT_LEN   = 104,
  parameter int ENTRY_DATA_WIDTH = 171,
  parameter int HOP_BIT_LEN      = 5
);
  logic                        start_valid;
  logic                        start_ready;
  logic [INDEX_BIT_LEN-1:0]    start_index;
  logic [PACKET_BIT_LEN-1:0]   start_tuple;

  logic                        upd_valid;
  logic                        upd_ready;
  logic [INDEX_BIT_LEN-1:0]    upd_index;
  logic [ENTRY_DATA_WIDTH-1:0] upd_din;

  logic [INDEX_BIT_LEN-1:0]    tbl_search_index;
  logic [PACKET_BIT_LEN-1:0]   tbl_tupleData;
  logic                        tbl_we;
  logic [ENTRY_DATA_WIDTH-1:0] tbl_din;
  logic                        tbl_match;
  logic [INDEX_BIT_LEN-1:0]    tbl_ruleID;
  logic [INDEX_BIT_LEN-1:0]    tbl_next_index;

  logic                        res_valid;
  logic                        res_ready;
  logic                        res_match;
  logic [INDEX_BIT_LEN-1:0]    res_ruleID;
  logic [HOP_BIT_LEN-1:0]      res_hops;
  logic                        res_overflow;

  modport slave (
    input  start_valid, start_index, start_tuple,
    output start_ready,
    input  upd_valid, upd_index, upd_din,
    output upd_ready,
    output tbl_search_index, tbl_tupleData, tbl_we, tbl_din,
    input  tbl_match, tbl_ruleID, tbl_next_index,
    output res_valid, res_match, res_ruleID, res_hops, res_overflow,
    input  res_ready
  );

  modport master (
    output start_valid, start_index, start_tuple,
    input  start_ready,
    output upd_valid, upd_index, upd_din,
    input  upd_ready,
    input  tbl_search_index, tbl_tupleData, tbl_we, tbl_din,
    output tbl_match, tbl_ruleID, tbl_next_index,
    input  res_valid, res_match, res_ruleID, res_hops, res_overflow,
    output res_ready
  );
endinterface

// File: rtl/g2_chain_walker.sv
// G2 chain walker: walks a linked chain of table entries for one search
// job, keeps the lowest matching ruleID, and slots entry writes from the
// update engine into the table port between searches.
module g2_chain_walker #(
  parameter int                   INDEX_BIT_LEN    = 11,
  parameter int                   PACKET_BIT_LEN   = 104,
  parameter int                   ENTRY_DATA_WIDTH = 171,
  parameter logic [INDEX_BIT_LEN-1:0] NULL_INDEX   = 11'h7FF,
  parameter int                   MAX_HOPS         = 19,
  parameter int                   HOP_BIT_LEN      = 5
) (
  input logic             clk,
  input logic             rst,
  g2_chain_walker_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                      state_q, state_d;
  logic [INDEX_BIT_LEN-1:0]    cur_q;
  logic [INDEX_BIT_LEN-1:0]    upd_idx_q;
  logic [ENTRY_DATA_WIDTH-1:0] din_q;
  logic [PACKET_BIT_LEN-1:0]   tuple_q;
  logic                        best_match_q;
  logic [INDEX_BIT_LEN-1:0]    best_rule_q;
  logic [HOP_BIT_LEN-1:0]      hops_q;
  logic                        ovf_q;

  logic better;
  logic chain_end;
  logic hop_limit;

  // The first match always wins (even ruleID all-ones); later ones only if strictly lower.
  assign better    = bus.tbl_match && (!best_match_q || (bus.tbl_ruleID < best_rule_q));
  assign chain_end = (bus.tbl_next_index == NULL_INDEX);
  assign hop_limit = (hops_q == HOP_BIT_LEN'(MAX_HOPS));

  // State register; reset aborts any walk in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Job/update latches, hop counter and best-result reduction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q        <= '0;
      upd_idx_q    <= '0;
      din_q        <= '0;
      tuple_q      <= '0;
      best_match_q <= 1'b0;
      best_rule_q  <= '1;
      hops_q       <= '0;
      ovf_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.upd_valid) begin
            upd_idx_q <= bus.upd_index;
            din_q     <= bus.upd_din;
          end else if (bus.start_valid) begin
            cur_q        <= bus.start_index;
            tuple_q      <= bus.start_tuple;
            best_match_q <= 1'b0;
            best_rule_q  <= '1;
            hops_q       <= '0;
            ovf_q        <= 1'b0;
          end
        end
        S_ISSUE: hops_q <= hops_q + HOP_BIT_LEN'(1);
        S_WAIT: begin
          if (better) begin
            best_match_q <= 1'b1;
            best_rule_q  <= bus.tbl_ruleID;
          end
          if (chain_end)      ovf_q <= 1'b0;
          else if (hop_limit) ovf_q <= 1'b1;
          else                cur_q <= bus.tbl_next_index;
        end
        default: ;
      endcase
    end
  end

  // Next-state decode and all handshake/table/result outputs.
  always_comb begin
    state_d              = state_q;
    bus.start_ready      = 1'b0;
    bus.upd_ready        = 1'b0;
    bus.tbl_search_index = '0;
    bus.tbl_tupleData    = '0;
    bus.tbl_we           = 1'b0;
    bus.tbl_din          = '0;
    bus.res_valid        = 1'b0;
    bus.res_match        = 1'b0;
    bus.res_ruleID       = '0;
    bus.res_hops         = '0;
    bus.res_overflow     = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.start_ready = !bus.upd_valid && !rst;
        if (bus.upd_valid)        state_d = S_WRITE;
        else if (bus.start_valid) state_d = (bus.start_index == NULL_INDEX) ? S_DONE : S_ISSUE;
      end
      S_WRITE: begin
        bus.tbl_search_index = upd_idx_q;
        bus.tbl_din          = din_q;
        bus.tbl_we           = 1'b1;
        bus.upd_ready        = 1'b1;
        state_d              = S_IDLE;
      end
      S_ISSUE: begin
        bus.tbl_search_index = cur_q;
        bus.tbl_tupleData    = tuple_q;
        state_d              = S_WAIT;
      end
      S_WAIT: begin
        bus.tbl_search_index = cur_q;
        bus.tbl_tupleData    = tuple_q;
        state_d              = (chain_end || hop_limit) ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        bus.res_valid    = 1'b1;
        bus.res_match    = best_match_q;
        bus.res_ruleID   = best_match_q ? best_rule_q : '0;
        bus.res_hops     = hops_q;
        bus.res_overflow = ovf_q;
        if (bus.res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_g2_chain_walker.sv
// Self-checking bench for g2_chain_walker: directed vector table, hand-written
// reset/update/stall sequences, and random chains checked against a walk model.
module tb_g2_chain_walker;

  localparam logic [10:0] NULL_IDX = 11'h7FF;
  localparam int          MAXH     = 19;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  g2_chain_walker_if #(
    .INDEX_BIT_LEN(11), .PACKET_BIT_LEN(104), .ENTRY_DATA_WIDTH(171), .HOP_BIT_LEN(5)
  ) bus ();

  g2_chain_walker #(
    .INDEX_BIT_LEN(11), .PACKET_BIT_LEN(104), .ENTRY_DATA_WIDTH(171),
    .NULL_INDEX(11'h7FF), .MAX_HOPS(19), .HOP_BIT_LEN(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Table contents, written only by the main initial block.
  logic        t_match [2048];
  logic [10:0] t_rule  [2048];
  logic [10:0] t_next  [2048];

  // Table model: registered read, outputs valid the cycle after the index.
  int           wr_count = 0;
  logic [10:0]  wr_idx;
  logic [170:0] wr_din;
  always @(posedge clk) begin
    bus.tbl_match      <= t_match[bus.tbl_search_index];
    bus.tbl_ruleID     <= t_rule[bus.tbl_search_index];
    bus.tbl_next_index <= t_next[bus.tbl_search_index];
    if (bus.tbl_we) begin
      wr_count <= wr_count + 1;
      wr_idx   <= bus.tbl_search_index;
      wr_din   <= bus.tbl_din;
    end
  end

  typedef struct {
    logic        m;
    logic [10:0] r;
    logic [4:0]  h;
    logic        o;
  } res_t;

  typedef struct {
    logic [10:0] idx;
    int          delay;
    res_t        exp;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Walk model: follow next pointers, count lookups, keep the lowest matching rule.
  function automatic res_t model(input logic [10:0] start);
    res_t        r;
    logic [10:0] idx;
    r.m = 1'b0; r.r = '0; r.h = '0; r.o = 1'b0;
    if (start == NULL_IDX) return r;
    idx = start;
    for (int unsigned k = 1; k <= MAXH; k++) begin
      r.h = 5'(k);
      if (t_match[idx] && (!r.m || t_rule[idx] < r.r)) begin
        r.m = 1'b1;
        r.r = t_rule[idx];
      end
      if (t_next[idx] == NULL_IDX) return r;
      idx = t_next[idx];
    end
    r.o = 1'b1;
    return r;
  endfunction

  task automatic run_job(input logic [10:0] idx, input logic [103:0] tup, input int delay,
                         output res_t got, output int lat, output logic tuple_ok,
                         output logic stable, output logic dropped, output logic ok);
    int n;
    ok = 1'b0; stable = 1'b1; tuple_ok = 1'b1; dropped = 1'b0; lat = 0;
    got.m = 1'b0; got.r = '0; got.h = '0; got.o = 1'b0;
    @(negedge clk);
    bus.start_valid = 1'b1;
    bus.start_index = idx;
    bus.start_tuple = tup;
    n = 0;
    while (!bus.start_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.start_ready) begin
      bus.start_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.start_valid = 1'b0;
    lat = 1;
    while (!bus.res_valid && lat < 100) begin
      if (bus.tbl_tupleData !== tup) tuple_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (!bus.res_valid) return;
    got.m = bus.res_match; got.r = bus.res_ruleID; got.h = bus.res_hops; got.o = bus.res_overflow;
    for (int d = 0; d < delay; d++) begin
      @(negedge clk);
      if (!bus.res_valid || bus.res_match !== got.m || bus.res_ruleID !== got.r ||
          bus.res_hops !== got.h || bus.res_overflow !== got.o) stable = 1'b0;
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    dropped = !bus.res_valid;
    ok = 1'b1;
  endtask

  task automatic job_and_check(input string tag, input logic [10:0] idx, input logic [103:0] tup,
                               input int delay, input res_t exp);
    res_t got;
    int   lat;
    logic tuple_ok, stable, dropped, ok;
    run_job(idx, tup, delay, got, lat, tuple_ok, stable, dropped, ok);
    check({tag, "_completed"}, ok, 1'b1);
    if (!ok) return;
    check({tag, "_match"},    got.m, exp.m);
    check({tag, "_ruleID"},   got.r, exp.r);
    check({tag, "_hops"},     got.h, exp.h);
    check({tag, "_overflow"}, got.o, exp.o);
    check({tag, "_latency"},  lat, 2 * int'(exp.h) + 1);
    check({tag, "_tuple"},    tuple_ok, 1'b1);
    check({tag, "_stable"},   stable, 1'b1);
    check({tag, "_drop"},     dropped, 1'b1);
  endtask

  vec_t        vecs[$];
  logic [127:0] rnd;
  logic [103:0] tup;
  logic [191:0] rdin;
  logic [170:0] din;
  logic         seen;
  int           wr_before;
  res_t         e;

  initial begin
    bus.start_valid = 1'b0; bus.start_index = '0; bus.start_tuple = '0;
    bus.upd_valid = 1'b0; bus.upd_index = '0; bus.upd_din = '0;
    bus.res_ready = 1'b0;
    for (int i = 0; i < 2048; i++) begin
      t_match[i] = 1'b0; t_rule[i] = '0; t_next[i] = NULL_IDX;
    end
    // Directed chains.
    t_next[3] = 11'd7;
    t_match[7] = 1'b1; t_rule[7] = 11'd42;
    t_match[0] = 1'b1; t_rule[0] = 11'd9; t_next[0] = 11'd1;
    t_match[1] = 1'b1; t_rule[1] = 11'd4; t_next[1] = 11'd2;
    t_match[2] = 1'b1; t_rule[2] = 11'd4;
    t_match[5] = 1'b1; t_rule[5] = 11'd100; t_next[5] = 11'd5;
    t_next[19] = 11'd20;
    for (int i = 0; i < 19; i++) begin
      t_match[20 + i] = (i % 2 == 0);
      t_rule[20 + i]  = 11'(300 + i);
      t_next[20 + i]  = (i == 18) ? NULL_IDX : 11'(21 + i);
    end

    // Reset state.
    #12;
    check("rst_start_ready", bus.start_ready, 1'b0);
    check("rst_res_valid",   bus.res_valid, 1'b0);
    check("rst_tbl_we",      bus.tbl_we, 1'b0);
    check("rst_upd_ready",   bus.upd_ready, 1'b0);
    check("rst_tbl_index",   bus.tbl_search_index, 11'd0);
    check("rst_tbl_din",     bus.tbl_din, 171'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vector table.
    vecs.push_back('{11'd3,   0, '{1'b1, 11'd42,  5'd2,  1'b0}});
    vecs.push_back('{11'd0,   1, '{1'b1, 11'd4,   5'd3,  1'b0}});
    vecs.push_back('{NULL_IDX,0, '{1'b0, 11'd0,   5'd0,  1'b0}});
    vecs.push_back('{11'd5,   2, '{1'b1, 11'd100, 5'd19, 1'b1}});
    vecs.push_back('{11'd20,  0, '{1'b1, 11'd300, 5'd19, 1'b0}});
    vecs.push_back('{11'd19,  0, '{1'b1, 11'd300, 5'd19, 1'b1}});
    vecs.push_back('{11'd10,  0, '{1'b0, 11'd0,   5'd1,  1'b0}});
    vecs.push_back('{11'd7,   0, '{1'b1, 11'd42,  5'd1,  1'b0}});
    foreach (vecs[i]) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      tup = rnd[103:0];
      job_and_check($sformatf("vec%0d", i), vecs[i].idx, tup, vecs[i].delay, vecs[i].exp);
    end

    // Update and search offered together; result then stalled 4 cycles.
    rdin = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    din = rdin[170:0];
    wr_before = wr_count;
    @(negedge clk);
    bus.upd_valid = 1'b1; bus.upd_index = 11'd1500; bus.upd_din = din;
    bus.start_valid = 1'b1; bus.start_index = 11'd3;
    #1 check("both_start_ready", bus.start_ready, 1'b0);
    @(negedge clk);
    check("wr_we",          bus.tbl_we, 1'b1);
    check("wr_index",       bus.tbl_search_index, 11'd1500);
    check("wr_din",         bus.tbl_din, din);
    check("wr_upd_ready",   bus.upd_ready, 1'b1);
    check("wr_start_ready", bus.start_ready, 1'b0);
    bus.upd_valid = 1'b0; bus.start_valid = 1'b0;
    @(negedge clk);
    check("wr_we_drop", bus.tbl_we, 1'b0);
    check("wr_count",   wr_count - wr_before, 1);
    check("wr_tbl_idx", wr_idx, 11'd1500);
    check("wr_tbl_din", wr_din, din);
    job_and_check("stall", 11'd3, 104'h1234, 4, '{1'b1, 11'd42, 5'd2, 1'b0});

    // Asynchronous reset during the WAIT of hop 2.
    @(negedge clk);
    bus.start_valid = 1'b1; bus.start_index = 11'd3; bus.start_tuple = 104'hABCD;
    @(posedge clk);
    @(negedge clk);
    bus.start_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_hop2_index", bus.tbl_search_index, 11'd7);
    #2 rst = 1'b1;
    #1;
    check("abort_index",       bus.tbl_search_index, 11'd0);
    check("abort_tuple",       bus.tbl_tupleData, 104'd0);
    check("abort_res_valid",   bus.res_valid, 1'b0);
    check("abort_start_ready", bus.start_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.res_valid) seen = 1'b1;
    end
    check("abort_no_result", seen, 1'b0);

    // Random chains in 1000..1063 checked against the walk model.
    for (int i = 1000; i < 1064; i++) begin
      t_match[i] = ($urandom_range(0, 2) == 0);
      t_rule[i]  = 11'($urandom_range(0, 2046));
      t_next[i]  = ($urandom_range(0, 4) == 0) ? NULL_IDX : 11'(1000 + $urandom_range(0, 63));
    end
    for (int j = 0; j < 40; j++) begin
      logic [10:0] s;
      s = ($urandom_range(0, 9) == 0) ? NULL_IDX : 11'(1000 + $urandom_range(0, 63));
      rnd = {$urandom, $urandom, $urandom, $urandom};
      tup = rnd[103:0];
      e = model(s);
      job_and_check($sformatf("rnd%0d", j), s, tup, int'($urandom_range(0, 3)), e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
